// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing for the 5-stage RV32I core: load-use bubbles, branch flushes,
// data-memory freeze, post-reset purge and saturating stall/flush counters.
package rv32_pkg;
   typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3} WBSel_t;
endpackage

module hazard_stall_ctrl
   import rv32_pkg::*;
#(
   parameter int INIT_CYCLES = 2,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_ID,
   input  logic [31:0]      inst_EX,
   input  logic             RegWEn_EX,
   input  WBSel_t           WBSel_EX,
   input  logic             BrTaken_EX,
   input  logic             dmem_req_MEM,
   input  logic             dmem_ready,
   output logic             stall_PC,
   output logic             stall_IF_ID,
   output logic             stall_ID_EX,
   output logic             stall_EX_MEM,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic             flush_MEM_WB,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);
   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT} state_t;

   state_t            state, state_nxt;
   logic [INIT_W-1:0] init_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              freeze, br_flush;

   logic [6:0] op_id;
   logic [4:0] rs1_id, rs2_id, rd_ex;
   logic       use_rs1, use_rs2, load_use, mem_stall;
   logic       unused_inst;

   assign op_id  = inst_ID[6:0];
   assign rs1_id = inst_ID[19:15];
   assign rs2_id = inst_ID[24:20];
   assign rd_ex  = inst_EX[11:7];
   assign unused_inst = ^{inst_ID[31:25], inst_EX[31:12], inst_EX[6:0]};

   assign use_rs1 = !(op_id == 7'b0110111 || op_id == 7'b0010111 || op_id == 7'b1101111);
   assign use_rs2 = (op_id == 7'b0110011 || op_id == 7'b0100011 || op_id == 7'b1100011);

   assign load_use = RegWEn_EX && (WBSel_EX == WB_MEM) && (rd_ex != 5'd0) &&
                     ((use_rs1 && rs1_id == rd_ex) || (use_rs2 && rs2_id == rd_ex));
   assign mem_stall = dmem_req_MEM && !dmem_ready;

   always_comb begin
      state_nxt    = state;
      freeze       = 1'b0;
      br_flush     = 1'b0;
      stall_PC     = 1'b0;
      stall_IF_ID  = 1'b0;
      stall_ID_EX  = 1'b0;
      stall_EX_MEM = 1'b0;
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      flush_MEM_WB = 1'b0;
      case (state)
         S_INIT: begin
            stall_PC    = 1'b1;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
            if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = S_RUN;
         end
         S_RUN, S_MEM_WAIT: begin
            // The release cycle of a wait is evaluated exactly like RUN.
            freeze = (state == S_RUN) ? mem_stall : !dmem_ready;
            if (freeze) begin
               stall_PC     = 1'b1;
               stall_IF_ID  = 1'b1;
               stall_ID_EX  = 1'b1;
               stall_EX_MEM = 1'b1;
               flush_MEM_WB = 1'b1;
               state_nxt    = S_MEM_WAIT;
            end else begin
               state_nxt = S_RUN;
               if (BrTaken_EX) begin
                  flush_IF_ID = 1'b1;
                  flush_ID_EX = 1'b1;
                  br_flush    = 1'b1;
               end else if (load_use) begin
                  stall_PC    = 1'b1;
                  stall_IF_ID = 1'b1;
                  flush_ID_EX = 1'b1;
               end
            end
         end
         default: state_nxt = S_INIT;
      endcase
   end

   // wait_cnt is zero on the first (RUN) freeze cycle and saturates one past the
   // pulse point so the timeout fires only once per wait.
   assign mem_timeout = freeze && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_INIT;
         init_cnt     <= '0;
         wait_cnt     <= '0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_INIT && init_cnt != INIT_W'(INIT_CYCLES - 1))
            init_cnt <= init_cnt + INIT_W'(1);
         if (freeze) begin
            if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WAIT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (stall_PC && state != S_INIT && !(&stall_cycles))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (br_flush && !(&flush_events))
            flush_events <= flush_events + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench: stimulus pushes hand-derived expectations, a negedge
// monitor pops and compares them against the controller outputs.
module tb_hazard_stall_ctrl;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_ID, inst_EX;
   logic        RegWEn_EX, BrTaken_EX, dmem_req_MEM, dmem_ready;
   WBSel_t      WBSel_EX;
   logic        stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
   logic        flush_IF_ID, flush_ID_EX, flush_MEM_WB, mem_timeout;
   logic [31:0] stall_cycles, flush_events;

   hazard_stall_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .inst_ID(inst_ID), .inst_EX(inst_EX),
      .RegWEn_EX(RegWEn_EX), .WBSel_EX(WBSel_EX), .BrTaken_EX(BrTaken_EX),
      .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
      .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
      .stall_EX_MEM(stall_EX_MEM), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
      .flush_MEM_WB(flush_MEM_WB), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_events(flush_events));

   always #5 clk = ~clk;

   // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX, flush_MEM_WB, mem_timeout}
   localparam logic [7:0] P_INIT = 8'b1000_1100;
   localparam logic [7:0] P_LU   = 8'b1100_0100;
   localparam logic [7:0] P_BR   = 8'b0000_1100;
   localparam logic [7:0] P_FRZ  = 8'b1111_0010;
   localparam logic [7:0] P_TO   = 8'b1111_0011;
   localparam logic [7:0] P_NONE = 8'b0000_0000;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] LW_X5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
   localparam logic [31:0] LW_X0   = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
   localparam logic [31:0] ADD_X5  = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
   localparam logic [31:0] ADD_X0  = {7'd0, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011};
   localparam logic [31:0] LUI_X5  = {12'd0, 5'd5, 3'b000, 5'd5, 7'b0110111};
   localparam logic [31:0] ADDI_I5 = {12'd5, 5'd1, 3'b000, 5'd7, 7'b0010011};
   localparam logic [31:0] SW_X5   = {7'd0, 5'd5, 5'd3, 3'b010, 5'd0, 7'b0100011};

   typedef struct {
      logic [7:0]  bits;
      logic [31:0] sc;
      logic [31:0] fe;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   logic        vec_vld = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_sc = 0;
   logic [31:0] m_fe = 0;

   // One cycle: drive inputs after the edge, queue the expectation, advance.
   task automatic step(input logic [31:0] id, input logic [31:0] ex, input logic rw,
                       input WBSel_t wb, input logic br, input logic req, input logic rdy,
                       input logic [7:0] pat, input string name);
      exp_t e;
      inst_ID = id; inst_EX = ex; RegWEn_EX = rw; WBSel_EX = wb;
      BrTaken_EX = br; dmem_req_MEM = req; dmem_ready = rdy;
      e.bits = pat; e.sc = m_sc; e.fe = m_fe; e.name = name;
      exp_q.push_back(e);
      vec_vld = 1'b1;
      if (pat[7] && pat != P_INIT) m_sc = m_sc + 1;
      if (pat == P_BR) m_fe = m_fe + 1;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (vec_vld) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL queue_underflow: no expectation queued for this cycle");
         end else begin
            exp_t e;
            logic [7:0] act;
            e = exp_q.pop_front();
            act = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                   flush_IF_ID, flush_ID_EX, flush_MEM_WB, mem_timeout};
            n_cmp++;
            if (act !== e.bits || stall_cycles !== e.sc || flush_events !== e.fe) begin
               n_bad++;
               $display("FAIL %s: got ctl=%b sc=%0d fe=%0d, want ctl=%b sc=%0d fe=%0d",
                        e.name, act, stall_cycles, flush_events, e.bits, e.sc, e.fe);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      inst_ID = NOP; inst_EX = NOP; RegWEn_EX = 0; WBSel_EX = WB_ALU;
      BrTaken_EX = 0; dmem_req_MEM = 0; dmem_ready = 0;
      repeat (2) @(posedge clk); #1;

      // T1: reset and purge
      step(NOP, NOP, 0, WB_ALU, 0, 0, 0, P_INIT, "in_reset");
      rst = 1'b0;
      step(NOP, LW_X5, 1, WB_MEM, 1, 0, 0, P_INIT, "init_cycle1");
      step(ADD_X5, LW_X5, 1, WB_MEM, 0, 1, 0, P_INIT, "init_cycle2");
      step(NOP, NOP, 0, WB_ALU, 0, 0, 0, P_NONE, "run_idle");

      // T2/T3: load-use decode
      step(ADD_X5, LW_X5, 1, WB_MEM, 0, 0, 0, P_LU, "lu_rs1");
      step(NOP, NOP, 0, WB_ALU, 0, 0, 0, P_NONE, "after_lu");
      step(ADD_X0, LW_X0, 1, WB_MEM, 0, 0, 0, P_NONE, "rd_x0");
      step(LUI_X5, LW_X5, 1, WB_MEM, 0, 0, 0, P_NONE, "lui_no_rs1");
      step(ADDI_I5, LW_X5, 1, WB_MEM, 0, 0, 0, P_NONE, "itype_no_rs2");
      step(ADD_X5, LW_X5, 0, WB_MEM, 0, 0, 0, P_NONE, "no_regwen");
      step(ADD_X5, LW_X5, 1, WB_ALU, 0, 0, 0, P_NONE, "wb_alu");
      step(SW_X5, LW_X5, 1, WB_MEM, 0, 0, 0, P_LU, "lu_rs2_store");

      // T4: branch beats load-use
      step(ADD_X5, LW_X5, 1, WB_MEM, 1, 0, 0, P_BR, "br_over_lu");
      step(NOP, NOP, 0, WB_ALU, 1, 0, 0, P_BR, "br_plain");
      step(NOP, NOP, 0, WB_ALU, 0, 0, 0, P_NONE, "after_br");

      // T5: memory wait and release
      step(NOP, NOP, 0, WB_ALU, 0, 1, 0, P_FRZ, "wait1");
      step(NOP, NOP, 0, WB_ALU, 0, 1, 0, P_FRZ, "wait2");
      step(NOP, NOP, 0, WB_ALU, 0, 1, 0, P_FRZ, "wait3");
      step(NOP, NOP, 0, WB_ALU, 0, 1, 1, P_NONE, "release");
      step(NOP, NOP, 0, WB_ALU, 0, 0, 0, P_NONE, "after_release");

      // Branch held through a freeze flushes only on the release cycle
      step(ADD_X5, LW_X5, 1, WB_MEM, 1, 1, 0, P_FRZ, "frz_over_br_run");
      step(ADD_X5, LW_X5, 1, WB_MEM, 1, 1, 0, P_FRZ, "frz_over_br_wait");
      step(ADD_X5, LW_X5, 1, WB_MEM, 1, 1, 1, P_BR, "release_br");
      step(ADD_X5, LW_X5, 1, WB_MEM, 0, 0, 0, P_LU, "lu_after_wait");

      // T6: timeout pulse on the 16th wait cycle only
      for (int i = 1; i <= 20; i++)
         step(NOP, NOP, 0, WB_ALU, 0, 1, 0, (i == 16) ? P_TO : P_FRZ, $sformatf("long_wait%0d", i));

      // Reset mid-wait
      rst = 1'b1;
      m_sc = 0; m_fe = 0;
      step(NOP, NOP, 0, WB_ALU, 0, 1, 0, P_INIT, "reset_mid_wait");
      rst = 1'b0;
      step(NOP, NOP, 0, WB_ALU, 0, 1, 0, P_INIT, "reinit1");
      step(NOP, NOP, 0, WB_ALU, 0, 1, 0, P_INIT, "reinit2");
      step(NOP, NOP, 0, WB_ALU, 0, 0, 0, P_NONE, "rerun_idle");

      vec_vld = 1'b0;
      if (exp_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
